// File: rtl/rx_ts_queue.sv
// ---------------------------------------------------------------------------
// rx_ts_queue
//
// Receive timestamp capture queue. Buffers up to DEPTH PTP event records
// (timestamp, fractional ns, sequenceId, messageType, sourcePortIdentity)
// captured by the rx timestamp engine, and presents the oldest record to the
// CPU/register read side in show-ahead form. Everything runs on rx_clk.
//
// Features:
//   - per-messageType capture filter (msg_mask_i)
//   - overflow policy: drop the new record, or overwrite the oldest record
//   - saturating overflow counter plus sticky overflow flag
//   - registered level interrupt (level threshold or sticky overflow)
//
// Ports:
//   rx_clk, rx_rst              clock, synchronous active-high reset
//   rx_clk_en_i                 gmii/mii clock enable; qualifies captures only
//   cap_*_i                     capture strobe and record fields
//   msg_mask_i                  bit n enables capture of messageType n
//   ovf_mode_i                  0 = drop new on full, 1 = overwrite oldest
//   irq_thresh_i                interrupt level threshold, 0 disables
//   flush_i                     discard every queued record
//   pop_i                       consume the head record
//   ovf_clr_i                   clear the overflow counter and sticky flag
//   rd_valid_o, rd_*_o          head record (all zero while empty)
//   level_o, full_o             fill level 0..DEPTH, full indication
//   ovf_cnt_o, ovf_sticky_o     overflow statistics
//   int_rx_ts_o                 level interrupt
// ---------------------------------------------------------------------------
module rx_ts_queue #(
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = 3,
   parameter int TS_W      = 80,
   parameter int OVF_CNT_W = 16
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic                 rx_clk_en_i,
   input  logic                 cap_valid_i,
   input  logic [TS_W-1:0]      cap_timestamp_i,
   input  logic [15:0]          cap_frac_ns_i,
   input  logic [15:0]          cap_seqId_i,
   input  logic [3:0]           cap_messageType_i,
   input  logic [79:0]          cap_sourcePortIdentity_i,
   input  logic [15:0]          msg_mask_i,
   input  logic                 ovf_mode_i,
   input  logic [ADDR_W:0]      irq_thresh_i,
   input  logic                 flush_i,
   input  logic                 pop_i,
   input  logic                 ovf_clr_i,
   output logic                 rd_valid_o,
   output logic [TS_W-1:0]      rd_timestamp_o,
   output logic [15:0]          rd_frac_ns_o,
   output logic [15:0]          rd_seqId_o,
   output logic [3:0]           rd_messageType_o,
   output logic [79:0]          rd_sourcePortIdentity_o,
   output logic [ADDR_W:0]      level_o,
   output logic                 full_o,
   output logic [OVF_CNT_W-1:0] ovf_cnt_o,
   output logic                 ovf_sticky_o,
   output logic                 int_rx_ts_o
);

   // Record layout inside one storage word, LSB first:
   // sourcePortIdentity | messageType | seqId | frac_ns | timestamp
   localparam int SPID_LSB = 0;
   localparam int TYPE_LSB = 80;
   localparam int SEQ_LSB  = 84;
   localparam int FRAC_LSB = 100;
   localparam int TS_LSB   = 116;
   localparam int ENTRY_W  = TS_LSB + TS_W;

   localparam logic [ADDR_W:0]      LP_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]      LP_LVL_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0]    LP_PTR_ONE = ADDR_W'(1);
   localparam logic [OVF_CNT_W-1:0] LP_CNT_ONE = OVF_CNT_W'(1);
   localparam logic [OVF_CNT_W-1:0] LP_CNT_MAX = '1;

   logic [ENTRY_W-1:0]   r_mem [DEPTH];
   logic [ADDR_W-1:0]    r_wrPtr;
   logic [ADDR_W-1:0]    r_rdPtr;
   logic [ADDR_W:0]      r_level;
   logic [OVF_CNT_W-1:0] r_ovfCnt;
   logic                 r_ovfSticky;
   logic                 r_int;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_write;
   logic                 w_ovfEvent;
   logic [ADDR_W-1:0]    w_wrPtrNext;
   logic [ADDR_W-1:0]    w_rdPtrNext;
   logic [ADDR_W:0]      w_levelNext;
   logic [OVF_CNT_W-1:0] w_ovfCntNext;
   logic                 w_stickyNext;
   logic                 w_intNext;
   logic [ENTRY_W-1:0]   w_entryIn;
   logic [ENTRY_W-1:0]   w_head;

   // A capture is only accepted when the MII/GMII clock enable is high and
   // its messageType is enabled in the mask. The read side pop is never
   // gated by the clock enable, only by the queue holding something.
   assign w_empty   = (r_level == '0);
   assign w_full    = (r_level == LP_DEPTH);
   assign w_push    = cap_valid_i & rx_clk_en_i & msg_mask_i[cap_messageType_i];
   assign w_pop     = pop_i & ~w_empty;
   assign w_entryIn = {cap_timestamp_i, cap_frac_ns_i, cap_seqId_i,
                       cap_messageType_i, cap_sourcePortIdentity_i};

   // Pointer and level next-state. Flush wins over everything. A push with
   // a pop always fits, even when full, because the pop frees a slot first.
   // A push on a full queue without a pop is an overflow: in overwrite mode
   // the write and read pointers are equal, so writing at the write pointer
   // replaces the oldest record and both pointers step past it.
   always_comb begin
      w_write     = 1'b0;
      w_ovfEvent  = 1'b0;
      w_wrPtrNext = r_wrPtr;
      w_rdPtrNext = r_rdPtr;
      w_levelNext = r_level;
      if (flush_i) begin
         w_wrPtrNext = '0;
         w_rdPtrNext = '0;
         w_levelNext = '0;
      end else if (w_push && w_pop) begin
         w_write     = 1'b1;
         w_wrPtrNext = r_wrPtr + LP_PTR_ONE;
         w_rdPtrNext = r_rdPtr + LP_PTR_ONE;
      end else if (w_push) begin
         if (!w_full) begin
            w_write     = 1'b1;
            w_wrPtrNext = r_wrPtr + LP_PTR_ONE;
            w_levelNext = r_level + LP_LVL_ONE;
         end else begin
            w_ovfEvent = 1'b1;
            if (ovf_mode_i) begin
               w_write     = 1'b1;
               w_wrPtrNext = r_wrPtr + LP_PTR_ONE;
               w_rdPtrNext = r_rdPtr + LP_PTR_ONE;
            end
         end
      end else if (w_pop) begin
         w_rdPtrNext = r_rdPtr + LP_PTR_ONE;
         w_levelNext = r_level - LP_LVL_ONE;
      end
   end

   // Overflow statistics next-state. A clear in the same cycle as an
   // overflow leaves exactly that one event recorded, so software never
   // loses an overflow that races with its own clear.
   always_comb begin
      w_ovfCntNext = r_ovfCnt;
      w_stickyNext = r_ovfSticky;
      if (ovf_clr_i) begin
         w_ovfCntNext = w_ovfEvent ? LP_CNT_ONE : '0;
         w_stickyNext = w_ovfEvent;
      end else if (w_ovfEvent) begin
         w_stickyNext = 1'b1;
         if (r_ovfCnt != LP_CNT_MAX) begin
            w_ovfCntNext = r_ovfCnt + LP_CNT_ONE;
         end
      end
   end

   // The interrupt is evaluated on next-state values so it is visible right
   // after the edge that crosses the threshold or records an overflow.
   always_comb begin
      w_intNext = ((irq_thresh_i != '0) && (w_levelNext >= irq_thresh_i))
                  || w_stickyNext;
   end

   // Control state. Reset discards all records by zeroing pointers and level.
   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_level     <= '0;
         r_ovfCnt    <= '0;
         r_ovfSticky <= 1'b0;
         r_int       <= 1'b0;
      end else begin
         r_wrPtr     <= w_wrPtrNext;
         r_rdPtr     <= w_rdPtrNext;
         r_level     <= w_levelNext;
         r_ovfCnt    <= w_ovfCntNext;
         r_ovfSticky <= w_stickyNext;
         r_int       <= w_intNext;
      end
   end

   // Record storage has no reset; stale contents are never visible because
   // the read side is masked whenever the level is zero.
   always_ff @(posedge rx_clk) begin
      if (!rx_rst && w_write) begin
         r_mem[r_wrPtr] <= w_entryIn;
      end
   end

   // Show-ahead read of the head record, forced to zero while empty.
   assign w_head = w_empty ? '0 : r_mem[r_rdPtr];

   assign rd_valid_o              = ~w_empty;
   assign rd_timestamp_o          = w_head[TS_LSB +: TS_W];
   assign rd_frac_ns_o            = w_head[FRAC_LSB +: 16];
   assign rd_seqId_o              = w_head[SEQ_LSB +: 16];
   assign rd_messageType_o        = w_head[TYPE_LSB +: 4];
   assign rd_sourcePortIdentity_o = w_head[SPID_LSB +: 80];
   assign level_o                 = r_level;
   assign full_o                  = w_full;
   assign ovf_cnt_o               = r_ovfCnt;
   assign ovf_sticky_o            = r_ovfSticky;
   assign int_rx_ts_o             = r_int;

endmodule

// File: tb/tb_rx_ts_queue.sv
// ---------------------------------------------------------------------------
// tb_rx_ts_queue
//
// Self-checking bench for rx_ts_queue. A behavioural queue model keeps the
// records that should be held; heads are compared whenever a record is
// consumed, and the full observable state is compared after every cycle.
// ---------------------------------------------------------------------------
module tb_rx_ts_queue;

   localparam int DEPTH     = 8;
   localparam int ADDR_W    = 3;
   localparam int TS_W      = 80;
   localparam int OVF_CNT_W = 16;

   logic                 rx_clk = 1'b0;
   logic                 rx_rst;
   logic                 rx_clk_en_i;
   logic                 cap_valid_i;
   logic [TS_W-1:0]      cap_timestamp_i;
   logic [15:0]          cap_frac_ns_i;
   logic [15:0]          cap_seqId_i;
   logic [3:0]           cap_messageType_i;
   logic [79:0]          cap_sourcePortIdentity_i;
   logic [15:0]          msg_mask_i;
   logic                 ovf_mode_i;
   logic [ADDR_W:0]      irq_thresh_i;
   logic                 flush_i;
   logic                 pop_i;
   logic                 ovf_clr_i;
   logic                 rd_valid_o;
   logic [TS_W-1:0]      rd_timestamp_o;
   logic [15:0]          rd_frac_ns_o;
   logic [15:0]          rd_seqId_o;
   logic [3:0]           rd_messageType_o;
   logic [79:0]          rd_sourcePortIdentity_o;
   logic [ADDR_W:0]      level_o;
   logic                 full_o;
   logic [OVF_CNT_W-1:0] ovf_cnt_o;
   logic                 ovf_sticky_o;
   logic                 int_rx_ts_o;

   rx_ts_queue #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TS_W(TS_W), .OVF_CNT_W(OVF_CNT_W)
   ) dut (
      .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_clk_en_i(rx_clk_en_i),
      .cap_valid_i(cap_valid_i), .cap_timestamp_i(cap_timestamp_i),
      .cap_frac_ns_i(cap_frac_ns_i), .cap_seqId_i(cap_seqId_i),
      .cap_messageType_i(cap_messageType_i),
      .cap_sourcePortIdentity_i(cap_sourcePortIdentity_i),
      .msg_mask_i(msg_mask_i), .ovf_mode_i(ovf_mode_i),
      .irq_thresh_i(irq_thresh_i), .flush_i(flush_i), .pop_i(pop_i),
      .ovf_clr_i(ovf_clr_i), .rd_valid_o(rd_valid_o),
      .rd_timestamp_o(rd_timestamp_o), .rd_frac_ns_o(rd_frac_ns_o),
      .rd_seqId_o(rd_seqId_o), .rd_messageType_o(rd_messageType_o),
      .rd_sourcePortIdentity_o(rd_sourcePortIdentity_o),
      .level_o(level_o), .full_o(full_o), .ovf_cnt_o(ovf_cnt_o),
      .ovf_sticky_o(ovf_sticky_o), .int_rx_ts_o(int_rx_ts_o)
   );

   // 100 MHz rx clock
   always #5 rx_clk = ~rx_clk;

   typedef struct {
      logic [15:0] seq;
      logic [3:0]  mtype;
   } rec_t;

   typedef struct {
      bit          push;
      logic [3:0]  mtype;
      logic [15:0] seq;
      bit          clkEn;
      bit          pop;
      bit          flush;
      logic [15:0] mask;
      int          expLevel;
      bit          expValid;
      logic [15:0] expHead;
   } vec_t;

   rec_t sb[$];
   int   mOvf;
   bit   mSticky;
   int   checkCount = 0;
   int   passCount  = 0;

   // Record fields are derived from the seqId so the model only stores seqId.
   function automatic logic [TS_W-1:0] tsOf(input logic [15:0] s);
      return {32'h0000_1000, s, s ^ 16'h3C3C, 16'h0100};
   endfunction

   function automatic logic [15:0] fracOf(input logic [15:0] s);
      return s ^ 16'hA5A5;
   endfunction

   function automatic logic [79:0] spidOf(input logic [15:0] s);
      return {48'hAABB_CCDD_EEFF, s, ~s};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkHead(input string name);
      if (sb.size() == 0) begin
         checkOutput({name, "_valid"}, 128'(rd_valid_o), 128'(0));
         checkOutput({name, "_seqZero"}, 128'(rd_seqId_o), 128'(0));
         checkOutput({name, "_tsZero"}, 128'(rd_timestamp_o), 128'(0));
         checkOutput({name, "_restZero"},
                     128'({rd_frac_ns_o, rd_messageType_o, rd_sourcePortIdentity_o}),
                     128'(0));
      end else begin
         checkOutput({name, "_valid"}, 128'(rd_valid_o), 128'(1));
         checkOutput({name, "_seq"}, 128'(rd_seqId_o), 128'(sb[0].seq));
         checkOutput({name, "_type"}, 128'(rd_messageType_o), 128'(sb[0].mtype));
         checkOutput({name, "_ts"}, 128'(rd_timestamp_o), 128'(tsOf(sb[0].seq)));
         checkOutput({name, "_frac"}, 128'(rd_frac_ns_o), 128'(fracOf(sb[0].seq)));
         checkOutput({name, "_spid"}, 128'(rd_sourcePortIdentity_o),
                     128'(spidOf(sb[0].seq)));
      end
   endtask

   task automatic checkState();
      bit expInt;
      expInt = ((irq_thresh_i != 0) && (sb.size() >= int'(irq_thresh_i))) || mSticky;
      checkOutput("level", 128'(level_o), 128'(sb.size()));
      checkOutput("full", 128'(full_o), 128'(sb.size() == DEPTH));
      checkHead("head");
      checkOutput("ovfCnt", 128'(ovf_cnt_o), 128'(mOvf));
      checkOutput("sticky", 128'(ovf_sticky_o), 128'(mSticky));
      checkOutput("int", 128'(int_rx_ts_o), 128'(expInt));
   endtask

   // Drives one cycle of stimulus and advances the model. The head is
   // compared against the scoreboard whenever a pop consumes it.
   task automatic applyStimulus(input bit push, input logic [3:0] mtype,
                                input logic [15:0] seq, input bit clkEn,
                                input bit pop, input bit flush, input bit clr);
      bit   doPush;
      bit   doPop;
      bit   ovfEv;
      rec_t r;
      cap_valid_i              = push;
      cap_messageType_i        = mtype;
      cap_seqId_i              = seq;
      cap_timestamp_i          = tsOf(seq);
      cap_frac_ns_i            = fracOf(seq);
      cap_sourcePortIdentity_i = spidOf(seq);
      rx_clk_en_i              = clkEn;
      pop_i                    = pop;
      flush_i                  = flush;
      ovf_clr_i                = clr;
      doPush = push && clkEn && msg_mask_i[mtype];
      doPop  = pop && (sb.size() != 0);
      if (doPop && !flush) checkHead("popHead");
      @(posedge rx_clk);
      #1;
      cap_valid_i = 1'b0;
      pop_i       = 1'b0;
      flush_i     = 1'b0;
      ovf_clr_i   = 1'b0;
      rx_clk_en_i = 1'b1;
      ovfEv = 1'b0;
      if (flush) begin
         sb.delete();
      end else begin
         if (doPop) void'(sb.pop_front());
         if (doPush) begin
            r.seq   = seq;
            r.mtype = mtype;
            if (sb.size() < DEPTH) begin
               sb.push_back(r);
            end else begin
               ovfEv = 1'b1;
               if (ovf_mode_i) begin
                  void'(sb.pop_front());
                  sb.push_back(r);
               end
            end
         end
      end
      if (clr) begin
         mOvf    = ovfEv ? 1 : 0;
         mSticky = ovfEv;
      end else if (ovfEv) begin
         mSticky = 1'b1;
         if (mOvf < 65535) mOvf++;
      end
   endtask

   task automatic pushSeq(input logic [15:0] seq);
      applyStimulus(1'b1, 4'd0, seq, 1'b1, 1'b0, 1'b0, 1'b0);
      checkState();
   endtask

   task automatic popOne();
      applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkState();
   endtask

   vec_t vecs[13];

   initial begin
      // Basic ordering, empty read-back, mask and clock-enable filtering,
      // and push+pop on an empty queue.
      vecs[0]  = '{1'b1, 4'd0, 16'd1, 1'b1, 1'b0, 1'b0, 16'h000F, 1, 1'b1, 16'd1};
      vecs[1]  = '{1'b1, 4'd0, 16'd2, 1'b1, 1'b0, 1'b0, 16'h000F, 2, 1'b1, 16'd1};
      vecs[2]  = '{1'b1, 4'd0, 16'd3, 1'b1, 1'b0, 1'b0, 16'h000F, 3, 1'b1, 16'd1};
      vecs[3]  = '{1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 16'h000F, 2, 1'b1, 16'd2};
      vecs[4]  = '{1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 16'h000F, 1, 1'b1, 16'd3};
      vecs[5]  = '{1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 16'h000F, 0, 1'b0, 16'd0};
      vecs[6]  = '{1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 16'h000F, 0, 1'b0, 16'd0};
      vecs[7]  = '{1'b1, 4'd1, 16'd4, 1'b1, 1'b0, 1'b0, 16'h0001, 0, 1'b0, 16'd0};
      vecs[8]  = '{1'b1, 4'd0, 16'd5, 1'b0, 1'b0, 1'b0, 16'h0001, 0, 1'b0, 16'd0};
      vecs[9]  = '{1'b1, 4'd0, 16'd6, 1'b1, 1'b0, 1'b0, 16'h0001, 1, 1'b1, 16'd6};
      vecs[10] = '{1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 16'h0001, 0, 1'b0, 16'd0};
      vecs[11] = '{1'b1, 4'd0, 16'd7, 1'b1, 1'b1, 1'b0, 16'h0001, 1, 1'b1, 16'd7};
      vecs[12] = '{1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 16'h0001, 0, 1'b0, 16'd0};

      rx_rst                   = 1'b1;
      rx_clk_en_i              = 1'b1;
      cap_valid_i              = 1'b0;
      cap_timestamp_i          = '0;
      cap_frac_ns_i            = '0;
      cap_seqId_i              = '0;
      cap_messageType_i        = '0;
      cap_sourcePortIdentity_i = '0;
      msg_mask_i               = 16'h000F;
      ovf_mode_i               = 1'b0;
      irq_thresh_i             = '0;
      flush_i                  = 1'b0;
      pop_i                    = 1'b0;
      ovf_clr_i                = 1'b0;
      mOvf                     = 0;
      mSticky                  = 1'b0;

      // Reset state
      repeat (2) @(posedge rx_clk);
      #1;
      rx_rst = 1'b0;
      checkState();

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         msg_mask_i = vecs[i].mask;
         applyStimulus(vecs[i].push, vecs[i].mtype, vecs[i].seq, vecs[i].clkEn,
                       vecs[i].pop, vecs[i].flush, 1'b0);
         checkOutput($sformatf("vec%0d_level", i), 128'(level_o), 128'(vecs[i].expLevel));
         checkOutput($sformatf("vec%0d_valid", i), 128'(rd_valid_o), 128'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d_head", i), 128'(rd_seqId_o), 128'(vecs[i].expHead));
         checkOutput($sformatf("vec%0d_ovf", i), 128'(ovf_cnt_o), 128'(0));
         checkState();
      end

      // Drop-new overflow, clear, full push+pop, clear racing an overflow,
      // and flush preserving the overflow state.
      msg_mask_i = 16'hFFFF;
      ovf_mode_i = 1'b0;
      for (int s = 0; s < 10; s++) pushSeq(16'(s));
      checkOutput("drop_level", 128'(level_o), 128'(8));
      checkOutput("drop_full", 128'(full_o), 128'(1));
      checkOutput("drop_head", 128'(rd_seqId_o), 128'(0));
      checkOutput("drop_ovf", 128'(ovf_cnt_o), 128'(2));
      checkOutput("drop_sticky", 128'(ovf_sticky_o), 128'(1));
      checkOutput("drop_int", 128'(int_rx_ts_o), 128'(1));
      applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("clr_ovf", 128'(ovf_cnt_o), 128'(0));
      checkOutput("clr_sticky", 128'(ovf_sticky_o), 128'(0));
      checkOutput("clr_int", 128'(int_rx_ts_o), 128'(0));
      checkState();
      applyStimulus(1'b1, 4'd0, 16'd20, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("fullPP_level", 128'(level_o), 128'(8));
      checkOutput("fullPP_ovf", 128'(ovf_cnt_o), 128'(0));
      checkOutput("fullPP_head", 128'(rd_seqId_o), 128'(1));
      checkState();
      applyStimulus(1'b1, 4'd0, 16'd21, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("clrRace_ovf", 128'(ovf_cnt_o), 128'(1));
      checkOutput("clrRace_sticky", 128'(ovf_sticky_o), 128'(1));
      checkState();
      applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("flush_level", 128'(level_o), 128'(0));
      checkOutput("flush_ovfKept", 128'(ovf_cnt_o), 128'(1));
      checkState();
      applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkState();

      // Overwrite-oldest overflow, then drain and check tail order.
      ovf_mode_i = 1'b1;
      for (int s = 0; s < 10; s++) pushSeq(16'(s));
      checkOutput("ovw_level", 128'(level_o), 128'(8));
      checkOutput("ovw_head", 128'(rd_seqId_o), 128'(2));
      checkOutput("ovw_ovf", 128'(ovf_cnt_o), 128'(2));
      repeat (7) popOne();
      checkOutput("ovw_tail", 128'(rd_seqId_o), 128'(9));
      popOne();
      applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkState();

      // Reset in the middle of operation discards everything.
      pushSeq(16'd40);
      pushSeq(16'd41);
      rx_rst = 1'b1;
      @(posedge rx_clk);
      #1;
      rx_rst = 1'b0;
      sb.delete();
      mOvf    = 0;
      mSticky = 1'b0;
      checkOutput("midRst_level", 128'(level_o), 128'(0));
      checkState();

      // Level threshold interrupt, then flush beating a push.
      ovf_mode_i   = 1'b0;
      irq_thresh_i = 4'd4;
      for (int s = 30; s < 33; s++) pushSeq(16'(s));
      checkOutput("irq_below", 128'(int_rx_ts_o), 128'(0));
      pushSeq(16'd33);
      checkOutput("irq_at", 128'(int_rx_ts_o), 128'(1));
      popOne();
      checkOutput("irq_drop", 128'(int_rx_ts_o), 128'(0));
      applyStimulus(1'b1, 4'd0, 16'd50, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("flushPush_level", 128'(level_o), 128'(0));
      checkState();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
